test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of monitored test channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 64, meaning width of the cycle counter and timeout limit.
REQ-003 SHALL have parameter STALL_LIMIT, default 1024, meaning idle cycles without heartbeat before a stall failure (0 = stall check disabled).
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  arm pulse; IDLE->RUN.
REQ-007 SHALL have port max_cycles  input  CNT_W  timeout limit in RUN cycles; 0 = no timeout; sampled every cycle.
REQ-008 SHALL have port ch_success  input  NUM_CH  per-channel success indication, level or pulse.
REQ-009 SHALL have port ch_fail  input  NUM_CH  per-channel failure indication.
REQ-010 SHALL have port ch_code  input  8*NUM_CH  per-channel failure code; channel i uses bits [8i+7:8i].
REQ-011 SHALL have port heartbeat  input  NUM_CH  per-channel progress pulse.
REQ-012 SHALL have port done  output  1  high in PASS or FAIL.
REQ-013 SHALL have port pass  output  1  high in PASS.
REQ-014 SHALL have port fail  output  1  high in FAIL.
REQ-015 SHALL have port fail_reason  output  2  0 none, 1 channel fail, 2 timeout, 3 stall.
REQ-016 SHALL have port fail_ch  output  max(1,clog2(NUM_CH))  index of the failing channel (0 for timeout).
REQ-017 SHALL have port fail_code  output  8  latched ch_code of fail_ch (reason 1 only; else 0).
REQ-018 SHALL have port cycle_count  output  CNT_W  RUN cycles elapsed.
REQ-019 SHALL have port done_mask  output  NUM_CH  sticky per-channel success flags.

Function
REQ-020 SHALL implement FSM IDLE, RUN, PASS, FAIL; PASS and FAIL are terminal until reset; start ignored outside IDLE.
REQ-021 SHALL move IDLE->RUN on the edge where start=1; ch_* and heartbeat inputs ignored in IDLE.
REQ-022 SHALL increment cycle_count by 1 on every edge in RUN, saturating at all-ones; frozen in PASS/FAIL.
REQ-023 SHALL set done_mask[i] on any RUN edge with ch_success[i]=1; bits never clear except by reset.
REQ-024 SHALL enter PASS on the edge after done_mask (including bits set that cycle) becomes all-ones with no fail condition that cycle.
REQ-025 SHALL enter FAIL reason 1 when any ch_fail[i]=1 in RUN; lowest index wins; fail_ch/fail_code latched that edge.
REQ-026 SHALL enter FAIL reason 2 when max_cycles!=0 and cycle_count>=max_cycles in RUN.
REQ-027 SHALL apply priority reason 1 > reason 2 > reason 3 > PASS when conditions coincide in one cycle.
REQ-028 SHALL register all outputs; an input event in cycle t is visible on done/pass/fail at t+1.
REQ-029 SHALL ignore ch_fail for channels whose done_mask bit is already set.

Reset
REQ-030 SHALL, on reset=0 at a clock edge, force state IDLE, cycle_count=0, done_mask=0, done=pass=fail=0, fail_reason=0, fail_ch=0, fail_code=0, stall counters=0, from any state including mid-RUN.

Configuration
REQ-031 SHALL, with TEST_MONITOR_STALL_EN defined, keep one counter per channel, cleared on heartbeat[i] or done_mask[i], incremented each RUN cycle otherwise, raising reason 3 (lowest index) when it reaches STALL_LIMIT (STALL_LIMIT!=0).
REQ-032 SHALL, without TEST_MONITOR_STALL_EN, instantiate no stall counters; fail_reason never equals 3 and heartbeat is unused.

Verification
REQ-033 SHALL cover: NUM_CH=4, start, ch_success bits 0..3 pulsed on RUN cycles 2,3,4,5 -> pass=1, fail_reason=0 one cycle after the last pulse, done_mask=4'hF.
REQ-034 SHALL cover: max_cycles=5, no success -> fail=1, fail_reason=2 once cycle_count reaches 5, cycle_count frozen at 5.
REQ-035 SHALL cover: ch_fail=4'b0110 with ch_code[15:8]=8'hA5 on the same cycle as final success -> fail_reason=1, fail_ch=1, fail_code=8'hA5, pass=0.
REQ-036 SHALL cover (macro defined, STALL_LIMIT=8): channel 2 heartbeat stops, others active -> fail_reason=3, fail_ch=2 after 8 idle RUN cycles; macro undefined -> no failure.
REQ-037 SHALL cover: reset=0 asserted mid-RUN at cycle_count=100 -> all outputs zero next edge; subsequent start re-runs from cycle_count=0.
REQ-038 SHALL cover: start pulsed in FAIL state, and ch_fail on an already-done channel -> no state change.

Source files
------------

// File: rtl/test_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : test_monitor
//  Description : Test-run supervisor. Armed by start, it counts RUN cycles,
//                collects sticky per-channel success flags and ends in a
//                terminal PASS or FAIL state. A failure is caused by a channel
//                fail (reason 1), a cycle-count timeout (reason 2) or a
//                per-channel heartbeat stall (reason 3).
//                Optional feature: define TEST_MONITOR_STALL_EN to build the
//                per-channel stall counters. Without it there are no stall
//                counters, heartbeat is unused and reason 3 never occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 64,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic [CNT_W-1:0]                               max_cycles,
    input  logic [NUM_CH-1:0]                              ch_success,
    input  logic [NUM_CH-1:0]                              ch_fail,
    input  logic [8*NUM_CH-1:0]                            ch_code,
    input  logic [NUM_CH-1:0]                              heartbeat,
    output logic                                           done,
    output logic                                           pass,
    output logic                                           fail,
    output logic [1:0]                                     fail_reason,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
    output logic [7:0]                                     fail_code,
    output logic [CNT_W-1:0]                               cycle_count,
    output logic [NUM_CH-1:0]                              done_mask
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] RSN_NONE    = 2'd0;
    localparam logic [1:0] RSN_CHFAIL  = 2'd1;
    localparam logic [1:0] RSN_TIMEOUT = 2'd2;
    localparam logic [1:0] RSN_STALL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [NUM_CH-1:0] mask_q,   mask_d;
    logic [1:0]        reason_q, reason_d;
    logic [CH_W-1:0]   fch_q,    fch_d;
    logic [7:0]        code_q,   code_d;
    logic              done_q,   done_d;
    logic              pass_q,   pass_d;
    logic              fail_q,   fail_d;

    // Combinational event detection for the current RUN cycle
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [NUM_CH-1:0] w_mask_next;
    logic [NUM_CH-1:0] w_fail_vec;
    logic              w_fail_any;
    logic [CH_W-1:0]   w_fail_idx;
    logic [7:0]        w_fail_code;
    logic              w_timeout;
    logic [NUM_CH-1:0] w_stall_vec;
    logic              w_stall_any;
    logic [CH_W-1:0]   w_stall_idx;

    // The counter saturates at all-ones instead of wrapping, so a very long
    // run can never alias back under max_cycles.
    assign w_cnt_inc   = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));

    // Successes seen this cycle count towards PASS on the same edge.
    assign w_mask_next = mask_q | ch_success;

    // A channel that has already reported success may no longer fail.
    assign w_fail_vec  = ch_fail & ~mask_q;
    assign w_fail_any  = |w_fail_vec;

    // Timeout compares the count this edge produces, so the counter freezes
    // exactly at max_cycles when the run is stopped.
    assign w_timeout   = (max_cycles != '0) && (w_cnt_inc >= max_cycles);

    assign w_stall_any = |w_stall_vec;

    // Lowest-index failing channel and its code (scan downwards so the lowest wins)
    always_comb begin
        w_fail_idx  = '0;
        w_fail_code = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_fail_vec[i]) begin
                w_fail_idx  = CH_W'(i);
                w_fail_code = ch_code[8*i +: 8];
            end
        end
    end

    // Lowest-index stalled channel
    always_comb begin
        w_stall_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_stall_vec[i]) begin
                w_stall_idx = CH_W'(i);
            end
        end
    end

`ifdef TEST_MONITOR_STALL_EN
    if (STALL_LIMIT != 0) begin : g_stall_on
        localparam int SC_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;

        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SC_W-1:0] stall_q, stall_d;
            logic            w_quiet;

            // A channel is idle when it neither beats nor is (becoming) done.
            assign w_quiet         = ~(heartbeat[gi] | w_mask_next[gi]);
            assign w_stall_vec[gi] = (state_q == ST_RUN) && w_quiet
                                     && (stall_q == SC_W'(STALL_LIMIT - 1));

            // Idle-cycle count: cleared by activity, advanced on idle RUN cycles
            always_comb begin
                stall_d = stall_q;
                if (state_q == ST_RUN) begin
                    if (w_quiet) begin
                        stall_d = stall_q + SC_W'(1);
                    end else begin
                        stall_d = '0;
                    end
                end
            end

            // Stall counter register
            always_ff @(posedge clk) begin
                if (!reset) begin
                    stall_q <= '0;
                end else begin
                    stall_q <= stall_d;
                end
            end
        end
    end else begin : g_stall_off
        logic w_hb_unused;
        assign w_hb_unused = ^heartbeat;
        assign w_stall_vec = '0;
    end
`else
    logic w_hb_unused;
    assign w_hb_unused = ^heartbeat;
    assign w_stall_vec = '0;
`endif

    // Next-state and next-output logic; PASS and FAIL hold everything frozen
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        reason_d = reason_q;
        fch_d    = fch_q;
        code_d   = code_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d  = w_cnt_inc;
                mask_d = w_mask_next;
                if (w_fail_any) begin
                    state_d  = ST_FAIL;
                    reason_d = RSN_CHFAIL;
                    fch_d    = w_fail_idx;
                    code_d   = w_fail_code;
                    done_d   = 1'b1;
                    fail_d   = 1'b1;
                end else if (w_timeout) begin
                    state_d  = ST_FAIL;
                    reason_d = RSN_TIMEOUT;
                    fch_d    = '0;
                    code_d   = '0;
                    done_d   = 1'b1;
                    fail_d   = 1'b1;
                end else if (w_stall_any) begin
                    state_d  = ST_FAIL;
                    reason_d = RSN_STALL;
                    fch_d    = w_stall_idx;
                    code_d   = '0;
                    done_d   = 1'b1;
                    fail_d   = 1'b1;
                end else if (&w_mask_next) begin
                    state_d  = ST_PASS;
                    reason_d = RSN_NONE;
                    done_d   = 1'b1;
                    pass_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            reason_q <= RSN_NONE;
            fch_q    <= '0;
            code_q   <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            reason_q <= reason_d;
            fch_q    <= fch_d;
            code_q   <= code_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_reason = reason_q;
    assign fail_ch     = fch_q;
    assign fail_code   = code_q;
    assign cycle_count = cnt_q;
    assign done_mask   = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_test_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_monitor
//  Description : Self-checking bench for test_monitor. Directed scenarios plus
//                randomized runs, compared each cycle against a behavioural
//                model of the run/pass/fail rules. A second small instance
//                (one channel, 3-bit counter) covers counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_monitor;

    localparam int NCH = 4;
    localparam int CW  = 64;
    localparam int SL  = 8;
`ifdef TEST_MONITOR_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset      = 1'b0;
    logic             start      = 1'b0;
    logic [CW-1:0]    max_cycles = '0;
    logic [NCH-1:0]   ch_success = '0;
    logic [NCH-1:0]   ch_fail    = '0;
    logic [8*NCH-1:0] ch_code    = '0;
    logic [NCH-1:0]   heartbeat  = '1;
    logic             done, pass, fail;
    logic [1:0]       fail_reason;
    logic [1:0]       fail_ch;
    logic [7:0]       fail_code;
    logic [CW-1:0]    cycle_count;
    logic [NCH-1:0]   done_mask;

    test_monitor #(.NUM_CH(NCH), .CNT_W(CW), .STALL_LIMIT(SL)) u_dut (
        .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
        .ch_success(ch_success), .ch_fail(ch_fail), .ch_code(ch_code),
        .heartbeat(heartbeat), .done(done), .pass(pass), .fail(fail),
        .fail_reason(fail_reason), .fail_ch(fail_ch), .fail_code(fail_code),
        .cycle_count(cycle_count), .done_mask(done_mask)
    );

    // Small instance: one channel, 3-bit counter
    logic       s_start = 1'b0;
    logic [2:0] s_max   = '0;
    logic [0:0] s_succ  = '0;
    logic [0:0] s_fail_in = '0;
    logic [7:0] s_code  = '0;
    logic [0:0] s_hb    = '1;
    logic       s_done, s_pass, s_fail;
    logic [1:0] s_reason;
    logic [0:0] s_fch;
    logic [7:0] s_fcode;
    logic [2:0] s_cnt;
    logic [0:0] s_mask;

    test_monitor #(.NUM_CH(1), .CNT_W(3), .STALL_LIMIT(0)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .max_cycles(s_max),
        .ch_success(s_succ), .ch_fail(s_fail_in), .ch_code(s_code),
        .heartbeat(s_hb), .done(s_done), .pass(s_pass), .fail(s_fail),
        .fail_reason(s_reason), .fail_ch(s_fch), .fail_code(s_fcode),
        .cycle_count(s_cnt), .done_mask(s_mask)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: 0 idle, 1 run, 2 pass, 3 fail
    int              m_state = 0;
    longint unsigned m_cnt   = 0;
    bit [NCH-1:0]    m_mask  = '0;
    int              m_reason = 0;
    int              m_ch     = 0;
    int              m_code   = 0;
    int              m_idle [NCH];

    function automatic void model_step();
        longint unsigned ncnt;
        bit [NCH-1:0]    nmask;
        int              nidle [NCH];
        int              fidx;
        int              sidx;
        if (!reset) begin
            m_state = 0; m_cnt = 0; m_mask = '0;
            m_reason = 0; m_ch = 0; m_code = 0;
            for (int i = 0; i < NCH; i++) m_idle[i] = 0;
            return;
        end
        if (m_state == 0) begin
            if (start) m_state = 1;
            return;
        end
        if (m_state != 1) return;
        ncnt  = (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) ? m_cnt : m_cnt + 1;
        nmask = m_mask | ch_success;
        fidx  = -1;
        sidx  = -1;
        for (int i = 0; i < NCH; i++) begin
            if (fidx < 0 && ch_fail[i] && !m_mask[i]) fidx = i;
            nidle[i] = (heartbeat[i] || nmask[i]) ? 0 : m_idle[i] + 1;
            if (STALL_EN && SL != 0 && sidx < 0 && nidle[i] >= SL) sidx = i;
        end
        if (fidx >= 0) begin
            m_state = 3; m_reason = 1; m_ch = fidx; m_code = int'(ch_code[fidx*8 +: 8]);
        end else if (max_cycles != 0 && ncnt >= max_cycles) begin
            m_state = 3; m_reason = 2; m_ch = 0; m_code = 0;
        end else if (sidx >= 0) begin
            m_state = 3; m_reason = 3; m_ch = sidx; m_code = 0;
        end else if (nmask == '1) begin
            m_state = 2;
        end
        m_cnt  = ncnt;
        m_mask = nmask;
        for (int i = 0; i < NCH; i++) m_idle[i] = nidle[i];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},   64'(done),        64'(m_state >= 2));
        chk({tag, ".pass"},   64'(pass),        64'(m_state == 2));
        chk({tag, ".fail"},   64'(fail),        64'(m_state == 3));
        chk({tag, ".reason"}, 64'(fail_reason), 64'(m_reason));
        chk({tag, ".ch"},     64'(fail_ch),     64'(m_ch));
        chk({tag, ".code"},   64'(fail_code),   64'(m_code));
        chk({tag, ".cnt"},    cycle_count,      m_cnt);
        chk({tag, ".mask"},   64'(done_mask),   64'(m_mask));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; ch_success = '0; ch_fail = '0;
        step("reset");
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        step("rst0");
        step("rst1");
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt",  cycle_count, 64'd0);
        reset = 1'b1;

        // All four channels succeed on consecutive cycles
        start = 1'b1; step("t1_start"); start = 1'b0;
        step("t1_c1");
        for (int k = 0; k < NCH; k++) begin
            ch_success = NCH'(1 << k);
            step("t1_succ");
        end
        ch_success = '0;
        chk("t1_pass",   64'(pass),        64'd1);
        chk("t1_reason", 64'(fail_reason), 64'd0);
        chk("t1_mask",   64'(done_mask),   64'hF);
        step("t1_hold");

        // Timeout at max_cycles=5
        do_reset();
        max_cycles = 5;
        start = 1'b1; step("t2_start"); start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) step("t2_run");
        chk("t2_fail",   64'(fail),        64'd1);
        chk("t2_reason", 64'(fail_reason), 64'd2);
        chk("t2_cnt",    cycle_count,      64'd5);
        for (int i = 0; i < 3; i++) step("t2_frozen");
        chk("t2_cnt_frozen", cycle_count, 64'd5);
        max_cycles = 0;

        // Channel fail coinciding with the final success; channel 2 already done
        do_reset();
        start = 1'b1; step("t3_start"); start = 1'b0;
        ch_success = 4'b1101; step("t3_pre");
        ch_code = {8'h3C, 8'h5A, 8'hA5, 8'h11};
        ch_success = 4'b0010; ch_fail = 4'b0110; step("t3_clash");
        ch_success = '0; ch_fail = '0;
        chk("t3_reason", 64'(fail_reason), 64'd1);
        chk("t3_ch",     64'(fail_ch),     64'd1);
        chk("t3_code",   64'(fail_code),   64'hA5);
        chk("t3_pass",   64'(pass),        64'd0);
        // start and ch_fail in FAIL change nothing
        start = 1'b1; step("t3_start_in_fail"); start = 1'b0;
        ch_fail = 4'b1111; ch_code = 32'hFFFF_FFFF; step("t3_fail_in_fail"); ch_fail = '0;
        chk("t3_code_kept", 64'(fail_code), 64'hA5);

        // ch_fail on an already-done channel is ignored
        do_reset();
        start = 1'b1; step("t4_start"); start = 1'b0;
        ch_success = 4'b0001; step("t4_s0"); ch_success = '0;
        ch_fail = 4'b0001; step("t4_fail_done"); ch_fail = '0;
        chk("t4_nofail", 64'(done), 64'd0);
        step("t4_after");

        // Reset mid-run at cycle_count=100, then re-run from zero
        do_reset();
        start = 1'b1; step("t5_start"); start = 1'b0;
        for (int i = 0; i < 200 && cycle_count != 100; i++) step("t5_run");
        chk("t5_at100", cycle_count, 64'd100);
        reset = 1'b0; step("t5_reset");
        chk("t5_cnt0",  cycle_count,      64'd0);
        chk("t5_mask0", 64'(done_mask),   64'd0);
        reset = 1'b1;
        start = 1'b1; step("t5_restart"); start = 1'b0;
        chk("t5_restart_cnt", cycle_count, 64'd0);
        step("t5_run1");
        chk("t5_run1_cnt", cycle_count, 64'd1);

        // Heartbeat of channel 2 stops
        do_reset();
        start = 1'b1; step("t6_start"); start = 1'b0;
        heartbeat = 4'b1011;
        for (int i = 0; i < 7; i++) step("t6_idle");
        chk("t6_not_yet", 64'(done), 64'd0);
        for (int i = 0; i < 5; i++) step("t6_more");
`ifdef TEST_MONITOR_STALL_EN
        chk("t6_reason", 64'(fail_reason), 64'd3);
        chk("t6_ch",     64'(fail_ch),     64'd2);
        chk("t6_cnt",    cycle_count,      64'd8);
`else
        chk("t6_nofail", 64'(fail),        64'd0);
        chk("t6_reason", 64'(fail_reason), 64'd0);
`endif
        heartbeat = '1;

        // Small instance: 3-bit counter saturates at 7
        do_reset();
        s_start = 1'b1; step("t7_start"); s_start = 1'b0;
        for (int i = 0; i < 3; i++) step("t7_run");
        chk("t7_cnt3", 64'(s_cnt), 64'd3);
        for (int i = 0; i < 7; i++) step("t7_run");
        chk("t7_cnt_sat", 64'(s_cnt), 64'd7);
        chk("t7_nodone",  64'(s_done), 64'd0);
        s_succ = 1'b1; step("t7_succ"); s_succ = 1'b0;
        chk("t7_pass", 64'(s_pass), 64'd1);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int hb_pct;
            do_reset();
            max_cycles = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 40));
            hb_pct = (r % 3 == 0) ? 40 : 90;
            start = 1'b1; step("rnd_start"); start = 1'b0;
            for (int c = 0; c < 60; c++) begin
                for (int i = 0; i < NCH; i++) begin
                    ch_success[i] = ($urandom_range(0, 11) == 0);
                    ch_fail[i]    = ($urandom_range(0, 39) == 0);
                    heartbeat[i]  = ($urandom_range(0, 99) < hb_pct);
                end
                ch_code = $urandom;
                start   = ($urandom_range(0, 15) == 0);
                reset   = ($urandom_range(0, 79) != 0);
                step("rnd");
            end
            reset = 1'b1; start = 1'b0; ch_success = '0; ch_fail = '0; heartbeat = '1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
